// File: rtl/serial_adder_sub_pkg.sv
// Shared types and elaboration helpers for the bit-serial adder/subtractor.
// The helpers are functions because the values depend on the instance parameters.
package serial_adder_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int num_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // The step counter needs at least one bit, even for single-step configurations.
    function automatic int step_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int bpc);
        return (width >= 2) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_sub_full_adder_cell.sv
// Single-bit combinational full adder; one link of the per-cycle ripple chain.
module full_adder_cell
    import serial_adder_sub_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB first, carry held
// in a flop between steps. Outputs update only on the final step.
module serial_adder_sub
    import serial_adder_sub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OVF
);

    localparam int NUM_STEPS = num_steps(WIDTH, BITS_PER_CYCLE);
    localparam int STEP_W    = step_width(NUM_STEPS);

    if (!params_ok(WIDTH, BITS_PER_CYCLE)) begin : g_param_check
        $error("serial_adder_sub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end

    state_t                    state_reg;
    state_t                    state_next;
    logic [WIDTH-1:0]          op_a_reg;
    logic [WIDTH-1:0]          op_b_reg;
    logic                      carry_reg;
    logic [STEP_W-1:0]         step_reg;
    logic [WIDTH-1:0]          res_reg;
    logic [WIDTH-1:0]          res_next;
    logic [WIDTH-1:0]          s_reg;
    logic                      cout_reg;
    logic                      ovf_reg;
    logic [BITS_PER_CYCLE:0]   chain_c;
    logic [BITS_PER_CYCLE-1:0] chain_s;
    logic                      accept;
    logic                      last_step;

    // Operands shift right each step, so the active chunk is always the low bits.
    assign chain_c[0] = carry_reg;
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_chain
        full_adder_cell u_cell (
            .A    (op_a_reg[gi]),
            .B    (op_b_reg[gi]),
            .Cin  (chain_c[gi]),
            .S    (chain_s[gi]),
            .Cout (chain_c[gi+1])
        );
    end

    // New sum chunk enters at the top; after NUM_STEPS steps chunk 0 sits at the LSB.
    assign res_next  = WIDTH'({chain_s, res_reg} >> BITS_PER_CYCLE);
    assign accept    = START && (state_reg != S_RUN);
    assign last_step = (step_reg == STEP_W'(NUM_STEPS - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (START) state_next = S_RUN;
            S_RUN:   if (last_step) state_next = S_DONE;
            S_DONE:  state_next = START ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_reg == S_RUN);
        DONE = (state_reg == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            carry_reg <= 1'b0;
            step_reg  <= '0;
            res_reg   <= '0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            // Subtract as A + ~B + ~Cin, which equals A - B - Cin modulo 2^WIDTH.
            op_a_reg  <= A;
            op_b_reg  <= SUB ? ~B : B;
            carry_reg <= SUB ? ~Cin : Cin;
            step_reg  <= '0;
        end else if (state_reg == S_RUN) begin
            op_a_reg  <= op_a_reg >> BITS_PER_CYCLE;
            op_b_reg  <= op_b_reg >> BITS_PER_CYCLE;
            carry_reg <= chain_c[BITS_PER_CYCLE];
            step_reg  <= step_reg + STEP_W'(1);
            res_reg   <= res_next;
            if (last_step) begin
                s_reg    <= res_next;
                cout_reg <= chain_c[BITS_PER_CYCLE];
                ovf_reg  <= chain_c[BITS_PER_CYCLE] ^ chain_c[BITS_PER_CYCLE-1];
            end
        end
    end

    assign S    = s_reg;
    assign Cout = cout_reg;
    assign OVF  = ovf_reg;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench: four configurations of serial_adder_sub checked against an
// integer-arithmetic reference model, plus handshake, latency and reset scenarios.
module tb_serial_adder_sub;

    localparam int W[4] = '{8, 8, 16, 4};
    localparam int N[4] = '{8, 2, 2, 2};

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic start[4];
    logic sub[4];
    logic cin[4];
    logic busy[4];
    logic done[4];
    logic cout[4];
    logic ovf[4];
    logic [7:0]  a0, b0, s0;
    logic [7:0]  a1, b1, s1;
    logic [15:0] a2, b2, s2;
    logic [3:0]  a3, b3, s3;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .START(start[0]), .SUB(sub[0]), .A(a0), .B(b0), .Cin(cin[0]),
        .BUSY(busy[0]), .DONE(done[0]), .S(s0), .Cout(cout[0]), .OVF(ovf[0]));
    serial_adder_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(start[1]), .SUB(sub[1]), .A(a1), .B(b1), .Cin(cin[1]),
        .BUSY(busy[1]), .DONE(done[1]), .S(s1), .Cout(cout[1]), .OVF(ovf[1]));
    serial_adder_sub #(.WIDTH(16), .BITS_PER_CYCLE(8)) u_dut2 (
        .CLK(CLK), .RST(RST), .START(start[2]), .SUB(sub[2]), .A(a2), .B(b2), .Cin(cin[2]),
        .BUSY(busy[2]), .DONE(done[2]), .S(s2), .Cout(cout[2]), .OVF(ovf[2]));
    serial_adder_sub #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_dut3 (
        .CLK(CLK), .RST(RST), .START(start[3]), .SUB(sub[3]), .A(a3), .B(b3), .Cin(cin[3]),
        .BUSY(busy[3]), .DONE(done[3]), .S(s3), .Cout(cout[3]), .OVF(ovf[3]));

    // Reference: signed/unsigned integer arithmetic on the mathematical values.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic ci, input logic sb,
                                  output logic [15:0] s, output logic c, output logic o);
        longint lim, ua, ub, sa, sbv, u, r;
        lim = longint'(1) << (w - 1);
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = (ua >= lim) ? ua - 2 * lim : ua;
        sbv = (ub >= lim) ? ub - 2 * lim : ub;
        if (!sb) begin
            u = ua + ub + longint'(ci);
            c = (u >= 2 * lim);
            r = sa + sbv + longint'(ci);
        end else begin
            u = ua - ub - longint'(ci);
            c = (u >= 0);
            r = sa - sbv - longint'(ci);
        end
        s = 16'(u & (2 * lim - 1));
        o = (r < -lim) || (r >= lim);
    endfunction

    function automatic logic [15:0] get_s(input int idx);
        case (idx)
            0:       return 16'(s0);
            1:       return 16'(s1);
            2:       return s2;
            default: return 16'(s3);
        endcase
    endfunction

    task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
        case (idx)
            0:       begin a0 = a[7:0]; b0 = b[7:0]; end
            1:       begin a1 = a[7:0]; b1 = b[7:0]; end
            2:       begin a2 = a;      b2 = b;      end
            default: begin a3 = a[3:0]; b3 = b[3:0]; end
        endcase
    endtask

    // Issues one request, scrambles the inputs after capture and waits for DONE.
    // lat is the number of cycles from the START edge to DONE (-1 on timeout).
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          output logic [15:0] s, output logic c, output logic o,
                          output int lat, output int busy_cnt);
        @(negedge CLK);
        set_ops(idx, a, b);
        cin[idx]   = ci;
        sub[idx]   = sb;
        start[idx] = 1'b1;
        @(negedge CLK);
        start[idx] = 1'b0;
        set_ops(idx, 16'($urandom), 16'($urandom));
        cin[idx] = 1'($urandom);
        sub[idx] = 1'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (done[idx] !== 1'b1 && lat < 200) begin
            if (busy[idx] === 1'b1) busy_cnt++;
            @(negedge CLK);
            lat++;
        end
        if (lat >= 200) lat = -1;
        s = get_s(idx);
        c = cout[idx];
        o = ovf[idx];
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({busy[i], done[i], get_s(i), cout[i], ovf[i]} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b s=%h cout=%b ovf=%b, required all zero",
                         i, busy[i], done[i], get_s(i), cout[i], ovf[i]);
            end
        end
        RST = 1'b0;
    endtask

    // Corner vectors scaled to the instance width: plain add, carry-out, signed
    // overflow on add, borrow on subtract, signed overflow on subtract, carry-in.
    task automatic test_corners(input int idx);
        logic [15:0] msk, maxpos, va[6], vb[6], s, es;
        logic        vc[6], vs[6], c, o, ec, eo;
        int          lat, bc;
        msk    = 16'((32'd1 << W[idx]) - 1);
        maxpos = msk >> 1;
        va = '{16'h35, msk, maxpos, 16'h10, maxpos + 16'd1, 16'h00};
        vb = '{16'h4A, 16'h01, 16'h01, 16'h20, 16'h01, 16'h00};
        vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            run_op(idx, va[k] & msk, vb[k] & msk, vc[k], vs[k], s, c, o, lat, bc);
            model(W[idx], va[k] & msk, vb[k] & msk, vc[k], vs[k], es, ec, eo);
            n_cmp++;
            if ({s, c, o} !== {es, ec, eo}) begin
                n_fail++;
                $display("FAIL corner_result dut%0d #%0d: got s=%h c=%b o=%b, required s=%h c=%b o=%b",
                         idx, k, s, c, o, es, ec, eo);
            end
            n_cmp++;
            if (lat !== N[idx] || bc !== N[idx] || busy[idx] !== 1'b0) begin
                n_fail++;
                $display("FAIL corner_timing dut%0d #%0d: latency=%0d busy_cycles=%0d busy_at_done=%b, required %0d %0d 0",
                         idx, k, lat, bc, busy[idx], N[idx], N[idx]);
            end
            @(negedge CLK);
            n_cmp++;
            if (done[idx] !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse_width dut%0d #%0d: done=%b one cycle after pulse, required 0",
                         idx, k, done[idx]);
            end
        end
    endtask

    task automatic test_random(input int idx, input int count);
        logic [15:0] a, b, s, es, msk;
        logic        ci, sb, c, o, ec, eo;
        int          lat, bc;
        msk = 16'((32'd1 << W[idx]) - 1);
        for (int k = 0; k < count; k++) begin
            a  = 16'($urandom) & msk;
            b  = 16'($urandom) & msk;
            ci = 1'($urandom);
            sb = 1'($urandom);
            run_op(idx, a, b, ci, sb, s, c, o, lat, bc);
            model(W[idx], a, b, ci, sb, es, ec, eo);
            n_cmp++;
            if ({s, c, o, lat} !== {es, ec, eo, N[idx]}) begin
                n_fail++;
                $display("FAIL random dut%0d a=%h b=%h cin=%b sub=%b: got s=%h c=%b o=%b lat=%0d, required s=%h c=%b o=%b lat=%0d",
                         idx, a, b, ci, sb, s, c, o, lat, es, ec, eo, N[idx]);
            end
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [15:0] s, es;
        logic        c, o, ec, eo;
        int          lat, bc;
        for (int m = 0; m < 1024; m++) begin
            run_op(3, 16'(m & 15), 16'((m >> 4) & 15), 1'((m >> 8) & 1), 1'((m >> 9) & 1),
                   s, c, o, lat, bc);
            model(4, 16'(m & 15), 16'((m >> 4) & 15), 1'((m >> 8) & 1), 1'((m >> 9) & 1),
                  es, ec, eo);
            n_cmp++;
            if ({s, c, o} !== {es, ec, eo}) begin
                n_fail++;
                $display("FAIL exhaustive_w4 a=%0d b=%0d cin=%0d sub=%0d: got s=%h c=%b o=%b, required s=%h c=%b o=%b",
                         m & 15, (m >> 4) & 15, (m >> 8) & 1, (m >> 9) & 1, s, c, o, es, ec, eo);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] es;
        logic        ec, eo;
        int          lat;
        @(negedge CLK);
        set_ops(0, 16'h12, 16'h34);
        cin[0] = 1'b0; sub[0] = 1'b0; start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        lat = 0;
        repeat (2) begin @(negedge CLK); lat++; end
        set_ops(0, 16'hAA, 16'hAA);
        sub[0] = 1'b1; start[0] = 1'b1;
        @(negedge CLK);
        lat++;
        start[0] = 1'b0;
        while (done[0] !== 1'b1 && lat < 200) begin @(negedge CLK); lat++; end
        model(8, 16'h12, 16'h34, 1'b0, 1'b0, es, ec, eo);
        n_cmp++;
        if ({get_s(0), cout[0], ovf[0], lat} !== {es, ec, eo, 8}) begin
            n_fail++;
            $display("FAIL start_while_busy: got s=%h c=%b o=%b lat=%0d, required s=%h c=%b o=%b lat=8",
                     get_s(0), cout[0], ovf[0], lat, es, ec, eo);
        end
        @(negedge CLK);
        n_cmp++;
        if ({busy[0], done[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_while_busy_queued: busy=%b done=%b after result, required 0 0",
                     busy[0], done[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] es;
        logic        ec, eo;
        int          lat, gap;
        @(negedge CLK);
        set_ops(0, 16'h11, 16'h22);
        cin[0] = 1'b0; sub[0] = 1'b0; start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        lat = 0;
        while (done[0] !== 1'b1 && lat < 200) begin @(negedge CLK); lat++; end
        model(8, 16'h11, 16'h22, 1'b0, 1'b0, es, ec, eo);
        n_cmp++;
        if ({get_s(0), lat} !== {es, 8}) begin
            n_fail++;
            $display("FAIL b2b_first: got s=%h lat=%0d, required s=%h lat=8", get_s(0), lat, es);
        end
        // Hold START in the DONE cycle.
        set_ops(0, 16'h01, 16'h02);
        start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        gap = 1;
        n_cmp++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b after START in DONE cycle, required 1", busy[0]);
        end
        while (done[0] !== 1'b1 && gap < 200) begin @(negedge CLK); gap++; end
        n_cmp++;
        if ({get_s(0), cout[0], ovf[0], gap} !== {16'h0003, 1'b0, 1'b0, 9}) begin
            n_fail++;
            $display("FAIL b2b_second: got s=%h c=%b o=%b done_gap=%0d, required s=0003 c=0 o=0 done_gap=9",
                     get_s(0), cout[0], ovf[0], gap);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic saw_done;
        @(negedge CLK);
        set_ops(0, 16'hF0, 16'h20);
        cin[0] = 1'b0; sub[0] = 1'b0; start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({busy[0], done[0], get_s(0), cout[0], ovf[0]} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_midrun_async: busy=%b done=%b s=%h c=%b o=%b, required all zero",
                     busy[0], done[0], get_s(0), cout[0], ovf[0]);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (done[0] !== 1'b0) saw_done = 1'b1;
        end
        RST = 1'b0;
        set_ops(0, 16'h05, 16'h06);
        start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        lat = 0;
        while (done[0] !== 1'b1 && lat < 200) begin
            if (lat > 0 && done[0] !== 1'b0) saw_done = 1'b1;
            @(negedge CLK);
            lat++;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun_no_done: stray done=%b seen, required 0", saw_done);
        end
        n_cmp++;
        if ({get_s(0), cout[0], ovf[0], lat} !== {16'h000B, 1'b0, 1'b0, 8}) begin
            n_fail++;
            $display("FAIL reset_midrun_restart: got s=%h c=%b o=%b lat=%0d, required s=000b c=0 o=0 lat=8",
                     get_s(0), cout[0], ovf[0], lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            sub[i]   = 1'b0;
            cin[i]   = 1'b0;
            set_ops(i, 16'h0, 16'h0);
        end
        test_reset();
        test_corners(0);
        test_corners(1);
        test_corners(2);
        test_random(0, 20);
        test_random(1, 20);
        test_random(2, 20);
        test_exhaustive_w4();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
